// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch stage: the fetch state
// encoding and the default widths / reset PC used by fetch_unit.
package fetch_pkg;

    // Default word-address width of the PC and instruction memory
    localparam int DEFAULT_PC_W = 32;

    // Default instruction width
    localparam int DEFAULT_INSTR_W = 32;

    // Default PC loaded on reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

    // ISSUE: a request may go out this cycle
    // WAIT : one request outstanding, waiting for its response
    // HOLD : an instruction is presented to IF/ID until it is consumed
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage. It owns the word-addressed PC, keeps at most one
// request outstanding to a variable-latency instruction memory, and holds
// the fetched instruction until the IF/ID register captures it. Redirects
// from a later stage override the PC and throw away anything in flight.
//
// Ports:
//   clk          clock, all state updates on posedge
//   clr_n        asynchronous active-low reset
//   stall        hazard-unit stall (same signal that stalls IF/ID)
//   PCSrc        one-cycle redirect pulse
//   PCBranch     redirect target, valid with PCSrc
//   imem_req     request strobe, always accepted the same cycle
//   imem_addr    request word address
//   imem_rvalid  response valid, at least one cycle after its request
//   imem_rdata   response data
//   IMRD         instruction presented to IF/ID
//   PCp1         address of IMRD plus one
//   FFClr        IF/ID clear: no valid instruction, or redirect active
//   pc_o         current PC (debug)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W              = DEFAULT_PC_W,
    parameter int INSTR_W           = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               stall,
    input  logic               PCSrc,
    input  logic [PC_W-1:0]    PCBranch,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IMRD,
    output logic [PC_W-1:0]    PCp1,
    output logic               FFClr,
    output logic [PC_W-1:0]    pc_o
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               outValid_q, outValid_d;
    logic               discard_q, discard_d;
    logic               consume;
    logic [PC_W-1:0]    pcPlusOne;

    assign pcPlusOne = pc_q + PC_W'(1);

    // The IF/ID register captures IMRD/PCp1 exactly when an instruction is
    // held and neither a stall nor a redirect blocks it.
    assign consume = (state_q == HOLD) && !stall && !PCSrc;

    // State register together with the PC, hold register and the flags.
    // Everything returns to a clean ISSUE at RESET_PC the moment reset
    // asserts, so a response still in flight is simply forgotten.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ISSUE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            outValid_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            outValid_q <= outValid_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state and datapath update. A redirect always wins: in WAIT it
    // marks the outstanding response for discard (or drops it if it arrives
    // the same cycle), in HOLD it throws away the held instruction even
    // while stalled. A consume in HOLD advances the PC and goes straight to
    // WAIT because the next request leaves in that same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        outValid_d = outValid_q;
        discard_d  = discard_q;
        case (state_q)
            ISSUE: begin
                if (PCSrc) begin
                    pc_d = PCBranch;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (PCSrc) begin
                    pc_d = PCBranch;
                end
                if (imem_rvalid) begin
                    if (discard_q || PCSrc) begin
                        discard_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        instr_d    = imem_rdata;
                        outValid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (PCSrc) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    outValid_d = 1'b0;
                    pc_d       = PCBranch;
                    state_d    = ISSUE;
                end else if (!stall) begin
                    outValid_d = 1'b0;
                    pc_d       = pcPlusOne;
                    state_d    = WAIT;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    // Memory request and IF/ID-facing outputs. The request strobe is gated
    // by reset so nothing is sent while the stage is held in reset.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            ISSUE: begin
                imem_req = !PCSrc;
            end
            HOLD: begin
                imem_req  = consume;
                imem_addr = pcPlusOne;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
        imem_req = imem_req && clr_n;
        IMRD     = instr_q;
        PCp1     = pcPlusOne;
        FFClr    = !outValid_q || PCSrc;
        pc_o     = pc_q;
    end

    // A response is only legal while a request is outstanding.
    assert property (@(posedge clk) disable iff (!clr_n)
        imem_rvalid |-> (state_q == WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Drives fetch_unit with a variable-latency memory model and checks the
// instructions captured by IF/ID against an ordered list of expected
// (instruction, PC+1) pairs.
module tb_fetch_unit;

    logic        clk;
    logic        clr_n;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCBranch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IMRD;
    logic [31:0] PCp1;
    logic        FFClr;
    logic [31:0] pc_o;

    int assertCount = 0;
    int failCount   = 0;

    // Memory model state: one pending request and its remaining latency
    logic        pending = 1'b0;
    logic [31:0] pendAddr = '0;
    int          cnt = 0;
    int          latency = 1;

    // Values sampled in the most recent cycle
    logic        sReq;
    logic [31:0] sAddr;
    logic        sFFClr;
    logic [31:0] sIMRD;
    logic [31:0] sPCp1;
    logic [31:0] sPc;

    // Expected IF/ID captures: {instruction, PC+1}
    logic [63:0] expQ[$];

    fetch_unit dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .stall      (stall),
        .PCSrc      (PCSrc),
        .PCBranch   (PCBranch),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .IMRD       (IMRD),
        .PCp1       (PCp1),
        .FFClr      (FFClr),
        .pc_o       (pc_o)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: address 0,1,2 hold 0x11,0x22,0x33 and so on
    function automatic logic [31:0] memFn(input logic [31:0] a);
        return 32'h11 * (a + 32'd1);
    endfunction

    // Single comparison point: counts and reports a mismatch
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expEntry(input logic [31:0] instr,
                                             input logic [31:0] pcp1);
        return {instr, pcp1};
    endfunction

    // One clock cycle, entered just after a falling edge: drive inputs and
    // the memory response, let things settle, sample outputs, feed the
    // memory model and the scoreboard, then move to the next falling edge.
    task automatic applyStimulus(input logic st, input logic pcs,
                                 input logic [31:0] br);
        logic [63:0] e;
        stall       = st;
        PCSrc       = pcs;
        PCBranch    = br;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pending) begin
            if (cnt == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memFn(pendAddr);
                pending     = 1'b0;
            end else begin
                cnt--;
            end
        end
        #1;
        sReq   = imem_req;
        sAddr  = imem_addr;
        sFFClr = FFClr;
        sIMRD  = IMRD;
        sPCp1  = PCp1;
        sPc    = pc_o;
        if (sReq) begin
            checkOutput("one_outstanding", {63'd0, pending}, 64'd0);
            pending  = 1'b1;
            pendAddr = sAddr;
            cnt      = latency;
        end
        if (clr_n && !sFFClr && !st) begin
            checkOutput("capture_expected", {63'd0, (expQ.size() != 0)}, 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("capture_IMRD", {32'd0, sIMRD}, {32'd0, e[63:32]});
                checkOutput("capture_PCp1", {32'd0, sPCp1}, {32'd0, e[31:0]});
            end
        end
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req"},   {63'd0, sReq},   64'd0);
        checkOutput({tag, "_FFClr"}, {63'd0, sFFClr}, 64'd1);
        checkOutput({tag, "_IMRD"},  {32'd0, sIMRD},  64'd0);
        checkOutput({tag, "_PCp1"},  {32'd0, sPCp1},  64'd1);
        checkOutput({tag, "_pc"},    {32'd0, sPc},    64'd0);
    endtask

    task automatic checkReq(input string tag, input logic [31:0] addr);
        checkOutput({tag, "_req"},  {63'd0, sReq},  64'd1);
        checkOutput({tag, "_addr"}, {32'd0, sAddr}, {32'd0, addr});
    endtask

    // Test sequence
    initial begin
        clr_n       = 1'b0;
        stall       = 1'b0;
        PCSrc       = 1'b0;
        PCBranch    = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        @(negedge clk);

        // Reset values
        applyStimulus(0, 0, 0);
        checkReset("reset");
        applyStimulus(0, 0, 0);
        clr_n = 1'b1;

        // Sequential fetch with 1-cycle memory, including a stall on 0x22
        expQ.push_back(expEntry(32'h11, 32'd1));
        expQ.push_back(expEntry(32'h22, 32'd2));
        expQ.push_back(expEntry(32'h33, 32'd3));
        applyStimulus(0, 0, 0);
        checkReq("first_req", 32'd0);
        checkOutput("first_FFClr", {63'd0, sFFClr}, 64'd1);
        applyStimulus(0, 0, 0);
        checkOutput("wait1_FFClr", {63'd0, sFFClr}, 64'd1);
        applyStimulus(0, 0, 0);
        checkReq("b2b_req", 32'd1);
        applyStimulus(0, 0, 0);
        checkOutput("wait2_FFClr", {63'd0, sFFClr}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("stall_IMRD",  {32'd0, sIMRD},  64'h22);
            checkOutput("stall_PCp1",  {32'd0, sPCp1},  64'd2);
            checkOutput("stall_FFClr", {63'd0, sFFClr}, 64'd0);
            checkOutput("stall_req",   {63'd0, sReq},   64'd0);
        end
        applyStimulus(0, 0, 0);
        checkReq("unstall_req", 32'd2);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkReq("req3", 32'd3);

        // Two more, then a 3-cycle fetch of address 5 that gets redirected
        expQ.push_back(expEntry(32'h44, 32'd4));
        expQ.push_back(expEntry(32'h55, 32'd5));
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        latency = 3;
        applyStimulus(0, 0, 0);
        checkReq("req5", 32'd5);
        applyStimulus(0, 0, 0);
        checkOutput("wait5a_FFClr", {63'd0, sFFClr}, 64'd1);
        applyStimulus(0, 1, 32'h40);
        checkOutput("redir_wait_FFClr", {63'd0, sFFClr}, 64'd1);
        applyStimulus(0, 0, 0);
        checkOutput("drop5_FFClr", {63'd0, sFFClr}, 64'd1);
        checkOutput("drop5_req",   {63'd0, sReq},   64'd0);
        latency = 1;
        expQ.push_back(expEntry(memFn(32'h40), 32'h41));
        applyStimulus(0, 0, 0);
        checkReq("req40", 32'h40);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkReq("req41", 32'h41);

        // Redirect while holding under stall: held 0x41 is never consumed
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("hold41_FFClr", {63'd0, sFFClr}, 64'd0);
        applyStimulus(1, 1, 32'h80);
        checkOutput("redir_hold_FFClr", {63'd0, sFFClr}, 64'd1);
        checkOutput("redir_hold_req",   {63'd0, sReq},   64'd0);
        applyStimulus(0, 0, 0);
        checkReq("req80", 32'h80);

        // Response and redirect in the same WAIT cycle, redirect to the top
        applyStimulus(0, 1, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 0);
        checkOutput("wrap_pc", {32'd0, sPc}, 64'hFFFF_FFFF);
        checkReq("reqTop", 32'hFFFF_FFFF);
        expQ.push_back(expEntry(memFn(32'hFFFF_FFFF), 32'd0));
        expQ.push_back(expEntry(32'h11, 32'd1));
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkReq("wrap_req", 32'd0);
        applyStimulus(0, 0, 0);
        latency = 3;
        applyStimulus(0, 0, 0);
        checkReq("req1_slow", 32'd1);

        // Reset mid-fetch; the late response arrives while still in reset
        applyStimulus(0, 0, 0);
        clr_n = 1'b0;
        applyStimulus(0, 0, 0);
        checkReset("midreset");
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkReset("late_rvalid");
        clr_n   = 1'b1;
        latency = 1;
        expQ.push_back(expEntry(32'h11, 32'd1));
        applyStimulus(0, 0, 0);
        checkReq("post_reset_req", 32'd0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);

        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
